olivia_retire_trace: RTL and testbench
======================================

Name: olivia_retire_trace

Overview:
- Hardware retirement-trace buffer for the Olivia LEGv8 core.
- Captures one record per retired instruction into a circular buffer: PC, instruction word, and register writeback.
- Freezes the buffer on a programmable trigger plus a post-trigger window, then streams the records out oldest-first over a valid/ready port.
- Sits beside the core datapath and taps the per-cycle instruction, PC and register-write signals; it is the on-chip successor to the simulation-only instruction monitor.

Parameters:
- WORD_W, 64, width of PC, write data, trigger value and trigger mask.
- INST_W, 32, instruction width.
- DEPTH, 16, number of trace entries; power of two, minimum 4.
- POST_TRIG, 4, entries captured after the trigger entry; legal range 0..DEPTH-1.
- CNT_W, 16, width of the dropped-retire counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rt_valid  in  1  one instruction retires this cycle.
- rt_pc  in  WORD_W  PC of the retiring instruction.
- rt_inst  in  INST_W  instruction word.
- rt_wr_en  in  1  instruction writes the register file.
- rt_wr_reg  in  5  destination register.
- rt_wr_data  in  WORD_W  writeback value.
- arm  in  1  single-cycle pulse; starts a capture.
- abort  in  1  single-cycle pulse; returns the block to IDLE.
- trig_mode  in  2  trigger source: 0 = first retire, 1 = instruction match, 2 = PC match, 3 = register-write match.
- trig_value  in  WORD_W  compare value.
- trig_mask  in  WORD_W  compare mask; 1 = bit compared.
- state  out  2  current state: 0 IDLE, 1 ARMED, 2 POST, 3 DUMP.
- count  out  log2(DEPTH)+1  valid entries in the buffer.
- trig_pos  out  log2(DEPTH)  readout index of the trigger entry.
- drop_cnt  out  CNT_W  retires ignored while in DUMP; saturating.
- out_valid  out  1  readout record is valid.
- out_ready  in  1  consumer accepts the record.
- out_pc  out  WORD_W  readout PC.
- out_inst  out  INST_W  readout instruction.
- out_wr_en  out  1  readout write-enable flag.
- out_wr_reg  out  5  readout destination register.
- out_wr_data  out  WORD_W  readout write data.
- out_last  out  1  final record of the dump.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; write pointer, count, trig_pos, drop_cnt, and all out_* fields = 0. Buffer RAM contents are not reset.
- IDLE: retires are ignored. arm -> ARMED, with write pointer and count cleared.
- ARMED:
  - Each rt_valid cycle writes one record at wr_ptr; wr_ptr increments mod DEPTH; count saturates at DEPTH, so the oldest record is overwritten.
  - Cycles with rt_valid=0 write nothing.
  - The trigger is evaluated only on rt_valid cycles, against the record being written in that same cycle:
    - Mode 0: always true.
    - Mode 1: (rt_inst & mask[INST_W-1:0]) == (value & mask)[INST_W-1:0].
    - Mode 2: (rt_pc & mask) == (value & mask).
    - Mode 3: rt_wr_en && rt_wr_reg == value[4:0]; mask ignored.
  - On trigger, the trigger record is written and post_left=POST_TRIG. Next state is POST, or DUMP if POST_TRIG=0.
- POST: each rt_valid writes a record and decrements post_left. The record that makes post_left reach 0 is written, and the block enters DUMP on that edge.
- Entering DUMP:
  - The oldest record is at (wr_ptr - count) mod DEPTH.
  - trig_pos = count - 1 - records captured after the trigger.
  - out_valid rises on the first cycle in DUMP.
- DUMP:
  - Each retire increments drop_cnt (saturating at 2^CNT_W-1); nothing is written.
  - out_* hold stable while out_valid && !out_ready.
  - On a handshake the read pointer advances. out_last=1 with the record at index count-1.
  - The handshake on out_last -> IDLE, out_valid=0 on the next cycle.
- arm is ignored outside IDLE. abort in any state -> IDLE next cycle, out_valid=0; drop_cnt is preserved.
- Reset at any time, including mid-POST or mid-DUMP, forces the reset values.
- drop_cnt clears only on reset or on arm.
- Simultaneous abort and arm in IDLE: abort wins; the block stays IDLE.
- Readout latency: out_* are registered; the next record is presented the cycle after a handshake, so throughput is 1 record per cycle with out_ready held high.

Test Plan:
- Reset: rst=0 while rt_valid=1 and arm=1 -> state=0, count=0, out_valid=0, drop_cnt=0; rst release then no arm -> count stays 0.
- Instruction trigger: DEPTH=8, POST_TRIG=3, mode 1, mask=0xFF000000, value=0xB4000000; arm; retire PCs 0,4,...,36 with the CBZ (0xB4000040) at PC 20.
  - Required: DUMP after the PC 32 retire; count=8.
  - Readout PCs 4,8,...,32; trig_pos=4; out_last on PC 32; the PC 36 retire gives drop_cnt=1.
- Early trigger: mode 2, value=0, mask all ones; arm; retire PCs 0,4,8,12,16 -> count=4; readout 0,4,8,12; trig_pos=0.
- Register-write trigger plus bubbles: mode 3, value=9; retires interleaved with rt_valid=0 gaps; ADD X9 at PC 12.
  - Required: only valid retires are stored.
  - The record at trig_pos has out_wr_en=1, out_wr_reg=9, and the correct out_wr_data.
- Backpressure: during DUMP hold out_ready=0 for 3 cycles -> out_* unchanged and no record is lost; full ordering is preserved after release.
- Abort and reset mid-operation:
  - abort in POST -> IDLE next cycle; a following arm restarts with count=0.
  - rst=0 mid-DUMP -> out_valid=0 immediately, state=0.

Source files
------------

// File: rtl/olivia_retire_trace.sv
// Retirement-trace buffer for the Olivia LEGv8 core: circular capture of retired
// instructions, trigger plus post-trigger freeze, then oldest-first valid/ready readout.
module olivia_retire_trace #(
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rt_valid,
    input  logic [WORD_W-1:0]          rt_pc,
    input  logic [INST_W-1:0]          rt_inst,
    input  logic                       rt_wr_en,
    input  logic [4:0]                 rt_wr_reg,
    input  logic [WORD_W-1:0]          rt_wr_data,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [1:0]                 trig_mode,
    input  logic [WORD_W-1:0]          trig_value,
    input  logic [WORD_W-1:0]          trig_mask,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   trig_pos,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic                       out_wr_en,
    output logic [4:0]                 out_wr_reg,
    output logic [WORD_W-1:0]          out_wr_data,
    output logic                       out_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DUMP  = 2'd3;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              wr_en;
        logic [4:0]        wr_reg;
        logic [WORD_W-1:0] wr_data;
    } rec_t;

    rec_t mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    post_left_q, post_left_d;
    logic [AW-1:0]    trig_pos_q, trig_pos_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_idx_q, rd_idx_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    rec_t             out_rec_q, out_rec_d;

    rec_t             rec_c;
    logic             trig_hit_c;
    logic             wr_en_c;
    logic             enter_dump_c;
    logic [AW-1:0]    oldest_c;
    logic [AW-1:0]    rd_nxt_c;

    assign rec_c = '{pc: rt_pc, inst: rt_inst, wr_en: rt_wr_en,
                     wr_reg: rt_wr_reg, wr_data: rt_wr_data};
    assign rd_nxt_c = rd_ptr_q + AW'(1);

    // Trigger compare against the record retiring this cycle
    always_comb begin
        trig_hit_c = 1'b0;
        case (trig_mode)
            2'd0: trig_hit_c = 1'b1;
            2'd1: trig_hit_c = ((rt_inst & trig_mask[INST_W-1:0]) ==
                                (trig_value[INST_W-1:0] & trig_mask[INST_W-1:0]));
            2'd2: trig_hit_c = ((rt_pc & trig_mask) == (trig_value & trig_mask));
            default: trig_hit_c = rt_wr_en && (rt_wr_reg == trig_value[4:0]);
        endcase
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        post_left_d  = post_left_q;
        trig_pos_d   = trig_pos_q;
        drop_d       = drop_q;
        rd_ptr_d     = rd_ptr_q;
        rd_idx_d     = rd_idx_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_rec_d    = out_rec_q;
        wr_en_c      = 1'b0;
        enter_dump_c = 1'b0;
        oldest_c     = '0;

        if (abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d  = S_ARMED;
                        wr_ptr_d = '0;
                        count_d  = '0;
                        drop_d   = '0;
                    end
                end
                S_ARMED: begin
                    if (rt_valid) begin
                        wr_en_c  = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
                        if (trig_hit_c) begin
                            post_left_d = AW'(POST_TRIG);
                            if (POST_TRIG == 0) begin
                                enter_dump_c = 1'b1;
                            end else begin
                                state_d = S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (rt_valid) begin
                        wr_en_c     = 1'b1;
                        wr_ptr_d    = wr_ptr_q + AW'(1);
                        count_d     = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
                        post_left_d = post_left_q - AW'(1);
                        if (post_left_q == AW'(1)) begin
                            enter_dump_c = 1'b1;
                        end
                    end
                end
                default: begin
                    if (rt_valid && (drop_q != {CNT_W{1'b1}})) begin
                        drop_d = drop_q + CNT_W'(1);
                    end
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_d     = S_IDLE;
                            out_valid_d = 1'b0;
                        end else begin
                            rd_ptr_d   = rd_nxt_c;
                            rd_idx_d   = rd_idx_q + AW'(1);
                            out_rec_d  = mem_q[rd_nxt_c];
                            out_last_d = ((CW'(rd_idx_q) + CW'(2)) == count_q);
                        end
                    end
                end
            endcase

            // Present the oldest record on the edge that freezes the buffer
            if (enter_dump_c) begin
                state_d     = S_DUMP;
                oldest_c    = wr_ptr_d - AW'(count_d);
                rd_ptr_d    = oldest_c;
                rd_idx_d    = '0;
                out_valid_d = 1'b1;
                out_last_d  = (count_d == CW'(1));
                out_rec_d   = (oldest_c == wr_ptr_q) ? rec_c : mem_q[oldest_c];
                trig_pos_d  = AW'(count_d - CW'(1) - CW'(POST_TRIG));
            end
        end
    end

    // Trace RAM, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= rec_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_left_q <= '0;
            trig_pos_q  <= '0;
            drop_q      <= '0;
            rd_ptr_q    <= '0;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_rec_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_left_q <= post_left_d;
            trig_pos_q  <= trig_pos_d;
            drop_q      <= drop_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_idx_q    <= rd_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_rec_q   <= out_rec_d;
        end
    end

    assign state       = state_q;
    assign count       = count_q;
    assign trig_pos    = trig_pos_q;
    assign drop_cnt    = drop_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_pc      = out_rec_q.pc;
    assign out_inst    = out_rec_q.inst;
    assign out_wr_en   = out_rec_q.wr_en;
    assign out_wr_reg  = out_rec_q.wr_reg;
    assign out_wr_data = out_rec_q.wr_data;

endmodule

// File: tb/tb_olivia_retire_trace.sv
// Directed bench for olivia_retire_trace with DEPTH=8, POST_TRIG=3.
module tb_olivia_retire_trace;

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned POST_TRIG = 3;
    localparam int unsigned CNT_W     = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rt_valid;
    logic [WORD_W-1:0] rt_pc;
    logic [INST_W-1:0] rt_inst;
    logic              rt_wr_en;
    logic [4:0]        rt_wr_reg;
    logic [WORD_W-1:0] rt_wr_data;
    logic              arm;
    logic              abort;
    logic [1:0]        trig_mode;
    logic [WORD_W-1:0] trig_value;
    logic [WORD_W-1:0] trig_mask;
    logic [1:0]        state;
    logic [3:0]        count;
    logic [2:0]        trig_pos;
    logic [CNT_W-1:0]  drop_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_wr_en;
    logic [4:0]        out_wr_reg;
    logic [WORD_W-1:0] out_wr_data;
    logic              out_last;

    int n_vec = 0;
    int n_err = 0;

    olivia_retire_trace #(
        .WORD_W(WORD_W), .INST_W(INST_W), .DEPTH(DEPTH),
        .POST_TRIG(POST_TRIG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .rt_valid(rt_valid), .rt_pc(rt_pc), .rt_inst(rt_inst),
        .rt_wr_en(rt_wr_en), .rt_wr_reg(rt_wr_reg), .rt_wr_data(rt_wr_data),
        .arm(arm), .abort(abort),
        .trig_mode(trig_mode), .trig_value(trig_value), .trig_mask(trig_mask),
        .state(state), .count(count), .trig_pos(trig_pos), .drop_cnt(drop_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_wr_en(out_wr_en),
        .out_wr_reg(out_wr_reg), .out_wr_data(out_wr_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [63:0] pc, input logic [31:0] inst,
                          input logic wen, input logic [4:0] wreg, input logic [63:0] wdata);
        rt_valid   = 1'b1;
        rt_pc      = pc;
        rt_inst    = inst;
        rt_wr_en   = wen;
        rt_wr_reg  = wreg;
        rt_wr_data = wdata;
        tick();
        rt_valid   = 1'b0;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic abort_pulse();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Drain a dump of n records with PCs pc0, pc0+4, ...; check the trigger record at tp
    task automatic read_seq(input logic [63:0] pc0, input int n, input int hold_at, input int tp,
                            input logic [31:0] tinst, input logic twen, input logic [4:0] treg,
                            input logic [63:0] tdata);
        for (int k = 0; k < n; k++) begin
            int budget;
            budget = 0;
            while (!out_valid && budget < 20) begin
                tick();
                budget++;
            end
            chk("rd_valid", 64'(out_valid), 64'd1);
            chk("rd_pc", out_pc, pc0 + 64'(4 * k));
            chk("rd_last", 64'(out_last), 64'(k == n - 1));
            if (k == tp) begin
                chk("rd_trig_inst", 64'(out_inst), 64'(tinst));
                chk("rd_trig_wen", 64'(out_wr_en), 64'(twen));
                chk("rd_trig_reg", 64'(out_wr_reg), 64'(treg));
                chk("rd_trig_data", out_wr_data, tdata);
            end
            if (k == hold_at) begin
                for (int h = 0; h < 3; h++) begin
                    out_ready = 1'b0;
                    tick();
                    chk("bp_valid", 64'(out_valid), 64'd1);
                    chk("bp_pc", out_pc, pc0 + 64'(4 * k));
                    chk("bp_last", 64'(out_last), 64'(k == n - 1));
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("rd_done_valid", 64'(out_valid), 64'd0);
        chk("rd_done_state", 64'(state), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst        = 1'b0;
        rt_valid   = 1'b1;
        rt_pc      = '0;
        rt_inst    = '0;
        rt_wr_en   = 1'b0;
        rt_wr_reg  = '0;
        rt_wr_data = '0;
        arm        = 1'b1;
        abort      = 1'b0;
        trig_mode  = 2'd0;
        trig_value = '0;
        trig_mask  = '0;
        out_ready  = 1'b0;

        // Reset held with activity on the inputs
        repeat (2) tick();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_trigpos", 64'(trig_pos), 64'd0);
        rst      = 1'b1;
        arm      = 1'b0;
        rt_valid = 1'b0;
        repeat (3) tick();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_state", 64'(state), 64'd0);

        // abort beats arm in IDLE
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        chk("abort_arm_state", 64'(state), 64'd0);

        // Instruction-match trigger on CBZ at PC 20
        trig_mode  = 2'd1;
        trig_mask  = 64'hFF00_0000;
        trig_value = 64'hB400_0000;
        arm_pulse();
        chk("A_armed", 64'(state), 64'd1);
        for (int i = 0; i < 10; i++) begin
            retire(64'(4 * i), (i == 5) ? 32'hB400_0040 : 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
            if (i == 4) chk("A_pre_trig", 64'(state), 64'd1);
            if (i == 5) chk("A_post", 64'(state), 64'd2);
            if (i == 8) begin
                chk("A_dump", 64'(state), 64'd3);
                chk("A_count", 64'(count), 64'd8);
                chk("A_trigpos", 64'(trig_pos), 64'd4);
                chk("A_valid", 64'(out_valid), 64'd1);
            end
            if (i == 9) begin
                chk("A_drop", 64'(drop_cnt), 64'd1);
                chk("A_hold_pc", out_pc, 64'd4);
            end
        end
        read_seq(64'd4, 8, -1, 4, 32'hB400_0040, 1'b0, 5'd0, 64'd0);

        // PC-match trigger on the very first retire
        trig_mode  = 2'd2;
        trig_mask  = '1;
        trig_value = '0;
        arm_pulse();
        chk("B_drop_clr", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 4; i++) retire(64'(4 * i), 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        chk("B_dump", 64'(state), 64'd3);
        chk("B_count", 64'(count), 64'd4);
        chk("B_trigpos", 64'(trig_pos), 64'd0);
        retire(64'd16, 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        chk("B_drop", 64'(drop_cnt), 64'd1);
        read_seq(64'd0, 4, -1, 0, 32'h8B00_0000, 1'b0, 5'd0, 64'd0);

        // Register-write trigger on X9 with bubbles, backpressure during readout
        trig_mode  = 2'd3;
        trig_mask  = '0;
        trig_value = 64'd9;
        arm_pulse();
        retire(64'd0, 32'h8B00_0000, 1'b1, 5'd1, 64'h11);
        tick();
        retire(64'd4, 32'h8B00_0000, 1'b1, 5'd2, 64'h22);
        tick();
        tick();
        retire(64'd8, 32'h8B00_0000, 1'b0, 5'd0, 64'h0);
        tick();
        retire(64'd12, 32'h8B02_0129, 1'b1, 5'd9, 64'hDEAD_BEEF_0000_1234);
        chk("C_post", 64'(state), 64'd2);
        tick();
        retire(64'd16, 32'h8B00_0000, 1'b1, 5'd9, 64'h99);
        tick();
        retire(64'd20, 32'h8B00_0000, 1'b0, 5'd0, 64'h0);
        chk("C_still_post", 64'(state), 64'd2);
        retire(64'd24, 32'h8B00_0000, 1'b0, 5'd0, 64'h0);
        chk("C_dump", 64'(state), 64'd3);
        chk("C_count", 64'(count), 64'd7);
        chk("C_trigpos", 64'(trig_pos), 64'd3);
        read_seq(64'd0, 7, 2, 3, 32'h8B02_0129, 1'b1, 5'd9, 64'hDEAD_BEEF_0000_1234);

        // Abort in POST, then restart
        trig_mode = 2'd0;
        arm_pulse();
        retire(64'd0, 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        chk("D_post", 64'(state), 64'd2);
        chk("D_count1", 64'(count), 64'd1);
        retire(64'd4, 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        abort_pulse();
        chk("D_abort_state", 64'(state), 64'd0);
        chk("D_abort_valid", 64'(out_valid), 64'd0);
        arm_pulse();
        chk("D_rearm_state", 64'(state), 64'd1);
        chk("D_rearm_count", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) retire(64'(4 * i), 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        chk("D_dump", 64'(state), 64'd3);
        retire(64'd16, 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        abort_pulse();
        chk("D_dump_abort", 64'(state), 64'd0);
        chk("D_drop_kept", 64'(drop_cnt), 64'd1);

        // Asynchronous reset in the middle of a dump
        arm_pulse();
        for (int i = 0; i < 4; i++) retire(64'(4 * i), 32'h8B00_0000, 1'b0, 5'd0, 64'd0);
        chk("E_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("E_rst_valid", 64'(out_valid), 64'd0);
        chk("E_rst_state", 64'(state), 64'd0);
        chk("E_rst_count", 64'(count), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
